collision_event_handler: RTL and testbench
==========================================

# collision_event_handler

Downstream consumer of the per-pixel collision detector in the Space Invaders VGA datapath. Accumulates pixel-level collision strobes over each video frame into sticky flags, evaluates them once per frame on the start-of-frame pulse, and converts them into single-cycle game events. Maintains lives, score, post-hit invulnerability and the game-over condition for the game-control logic and the score/lives display objects.

## Interface
Parameters:
- INIT_LIVES, 3: lives loaded at reset and restart; range 1..7.
- COOLDOWN_FRAMES, 60: invulnerable frames following a player hit; range 1..255.
- ALIEN_POINTS, 10: score added per frame containing an alien hit.
- SCORE_W, 16: score width in bits.

Ports:
- clk  in  1  system clock (pixel clock domain).
- resetN  in  1  reset, asynchronous, active-low.
- startOfFrame  in  1  one-cycle pulse, first cycle of each frame.
- collidePlayer  in  1  registered strobe: alien missile overlaps player pixel.
- collideAlien  in  1  registered strobe: player shot overlaps alien pixel.
- restart  in  1  one-cycle pulse; starts a new game.
- playerHit  out  1  one-cycle pulse: a player hit was accepted.
- alienHit  out  1  one-cycle pulse: an alien hit was scored.
- lives  out  3  remaining lives.
- score  out  SCORE_W  accumulated score, saturating.
- invulnerable  out  1  high while in COOLDOWN.
- gameOver  out  1  high while in GAME_OVER.

## Operation
- Two sticky flags, pFlag and aFlag. Each is set by its collide strobe on any cycle. On a startOfFrame cycle, each flag is loaded with that cycle's collide value, not OR-ed. A strobe coincident with startOfFrame therefore belongs to the new frame.
- Evaluation happens on the startOfFrame cycle and uses the flag values held before that edge.
- States: PLAY, COOLDOWN, GAME_OVER.
- PLAY:
  - If pFlag is set, assert playerHit and decrement lives.
  - If lives was 1, lives becomes 0 and the state goes to GAME_OVER.
  - Otherwise load cdCnt with COOLDOWN_FRAMES and go to COOLDOWN.
- COOLDOWN:
  - pFlag is ignored: no pulse, no decrement.
  - Each evaluation decrements cdCnt.
  - An evaluation with cdCnt==1 returns the state to PLAY. The next frame is hittable.
- Alien scoring:
  - In PLAY and COOLDOWN, a set aFlag asserts alienHit and adds ALIEN_POINTS to score.
  - Score saturates at 2^SCORE_W-1; no wrap.
  - At most one alien event is scored per frame, regardless of pixel count.
- A player hit and an alien hit in the same frame are both processed. Both pulses are asserted in the same cycle.
- GAME_OVER: flags are still tracked, but no events are produced. lives=0 and score are frozen. The state is sticky until restart.
- restart is accepted in any state and has priority over a coincident evaluation, whose events are discarded. It sets state to PLAY, lives to INIT_LIVES, score to 0, cdCnt to 0, and clears both flags (a coincident collide strobe is also discarded).
- Reset values: state PLAY, lives INIT_LIVES, score 0, cdCnt 0, flags 0, playerHit 0, alienHit 0, invulnerable 0, gameOver 0.

## Timing
- All outputs are registered.
- Events:
  - playerHit and alienHit go high in the cycle after the startOfFrame cycle, for exactly one cycle.
  - lives, score, invulnerable and gameOver update on the same edge as the pulses.
- Latency from the last collide strobe of frame N to its event: until the startOfFrame of frame N+1, plus 1 cycle.
- No handshake. Consumers sample the pulses and need not acknowledge them.
- An assertion of resetN mid-frame clears everything immediately (asynchronous). The first evaluation after release processes only strobes seen since release.
- No minimum spacing between startOfFrame pulses. Back-to-back pulses each evaluate; the second one sees flags loaded on the first.

## Structure
- Shared package game_pkg:
  - enum gameState_t {PLAY, COOLDOWN, GAME_OVER}.
  - localparam LIVES_W = 3.
  - Default constants for COOLDOWN_FRAMES and ALIEN_POINTS.
- Sub-module frame_sticky_flag, instantiated twice (player, alien).
  - Inputs: clk, resetN, startOfFrame, strobe, clear.
  - Output: flag, the value held before the current frame boundary.
- The top level holds the FSM, lives, score and cooldown counters, and the pulse registers.

## Test plan
- Alien hit during PLAY: three collideAlien strobes in one frame, then startOfFrame → exactly one alienHit pulse 1 cycle later; score 0→10.
- Player hit and cooldown (COOLDOWN_FRAMES=3):
  - collidePlayer in frame 0 → playerHit, lives 3→2, invulnerable=1.
  - collidePlayer in each of the next 3 frames → no pulses, lives stays 2.
  - After the 3rd evaluation, invulnerable=0; a hit in the following frame gives lives 2→1.
- Game over: INIT_LIVES=1, collidePlayer then startOfFrame → playerHit, lives=0, gameOver=1. Later collideAlien frames → no alienHit and score frozen.
- Coincidence: collidePlayer on the same cycle as startOfFrame → no event at that boundary; playerHit at the following startOfFrame.
- Restart priority: restart coincident with startOfFrame while pFlag and aFlag are set → no pulses; lives=INIT_LIVES, score=0, gameOver=0.
- Saturation and reset: SCORE_W=5, ALIEN_POINTS=10, four alien frames → score 10, 20, 30, 31. Asserting resetN mid-frame → all outputs return to reset values immediately.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-control types and constants for the Space Invaders datapath.
package game_pkg;

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        COOLDOWN  = 2'd1,
        GAME_OVER = 2'd2
    } gameState_t;

    localparam int LIVES_W = 3;
    localparam int CD_W    = 8;

    localparam int DEF_COOLDOWN_FRAMES = 60;
    localparam int DEF_ALIEN_POINTS    = 10;

endpackage

// File: rtl/frame_sticky_flag.sv
// Sticky per-frame flag. Accumulates a collide strobe across a frame. On the
// startOfFrame cycle the register still holds the previous frame's value,
// which is what the evaluator sees; it is then reloaded with that cycle's
// strobe, so a strobe coincident with startOfFrame counts for the new frame.
module frame_sticky_flag (
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    input  logic strobe,
    input  logic clear,
    output logic flag
);

    // Load on frame boundary, OR-accumulate otherwise; clear wins over both.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            flag <= 1'b0;
        end else if (clear) begin
            flag <= 1'b0;
        end else if (startOfFrame) begin
            flag <= strobe;
        end else if (strobe) begin
            flag <= 1'b1;
        end
    end

endmodule

// File: rtl/collision_event_handler.sv
// Collision event handler: turns per-pixel collision strobes into one game
// event per frame, and tracks lives, score, post-hit invulnerability and the
// game-over condition.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// PLAY      | player hittable; alien hits scored
// COOLDOWN  | player invulnerable for cd_cnt more evaluations; aliens scored
// GAME_OVER | lives exhausted; no events, lives/score frozen until restart
module collision_event_handler
    import game_pkg::*;
#(
    parameter int INIT_LIVES      = 3,
    parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
    parameter int ALIEN_POINTS    = DEF_ALIEN_POINTS,
    parameter int SCORE_W         = 16
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               collidePlayer,
    input  logic               collideAlien,
    input  logic               restart,
    output logic               playerHit,
    output logic               alienHit,
    output logic [LIVES_W-1:0] lives,
    output logic [SCORE_W-1:0] score,
    output logic               invulnerable,
    output logic               gameOver
);

    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(INIT_LIVES);
    localparam logic [LIVES_W-1:0] LIVES_ONE  = LIVES_W'(1);
    localparam logic [CD_W-1:0]    CD_LOAD    = CD_W'(COOLDOWN_FRAMES);
    localparam logic [CD_W-1:0]    CD_ONE     = CD_W'(1);
    localparam logic [SCORE_W:0]   POINTS     = (SCORE_W + 1)'(ALIEN_POINTS);

    gameState_t        state;
    logic [CD_W-1:0]   cd_cnt;
    logic              p_flag;
    logic              a_flag;
    logic              evaluate;
    logic [SCORE_W:0]  score_sum;
    logic [SCORE_W-1:0] score_sat;

    frame_sticky_flag u_player_flag (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .strobe       (collidePlayer),
        .clear        (restart),
        .flag         (p_flag)
    );

    frame_sticky_flag u_alien_flag (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .strobe       (collideAlien),
        .clear        (restart),
        .flag         (a_flag)
    );

    // restart pre-empts a coincident evaluation entirely.
    assign evaluate = startOfFrame && !restart;

    // Saturating add: carry out of the score width pins the result at all-ones.
    assign score_sum = {1'b0, score} + POINTS;
    assign score_sat = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

    // Game FSM with lives/score/cooldown bookkeeping and registered event pulses.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= PLAY;
            lives        <= LIVES_INIT;
            score        <= '0;
            cd_cnt       <= '0;
            playerHit    <= 1'b0;
            alienHit     <= 1'b0;
            invulnerable <= 1'b0;
            gameOver     <= 1'b0;
        end else begin
            playerHit <= 1'b0;
            alienHit  <= 1'b0;

            if (restart) begin
                state        <= PLAY;
                lives        <= LIVES_INIT;
                score        <= '0;
                cd_cnt       <= '0;
                invulnerable <= 1'b0;
                gameOver     <= 1'b0;
            end else if (evaluate) begin
                case (state)
                    PLAY: begin
                        if (p_flag) begin
                            playerHit <= 1'b1;
                            if (lives <= LIVES_ONE) begin
                                lives    <= '0;
                                state    <= GAME_OVER;
                                gameOver <= 1'b1;
                            end else begin
                                lives        <= lives - LIVES_ONE;
                                cd_cnt       <= CD_LOAD;
                                state        <= COOLDOWN;
                                invulnerable <= 1'b1;
                            end
                        end
                    end
                    COOLDOWN: begin
                        // <= also recovers from a zero count instead of locking up.
                        if (cd_cnt <= CD_ONE) begin
                            cd_cnt       <= '0;
                            state        <= PLAY;
                            invulnerable <= 1'b0;
                        end else begin
                            cd_cnt <= cd_cnt - CD_ONE;
                        end
                    end
                    default: begin
                        state <= GAME_OVER;
                    end
                endcase

                if (state != GAME_OVER && a_flag) begin
                    alienHit <= 1'b1;
                    score    <= score_sat;
                end
            end
        end
    end

endmodule

// File: tb/tb_collision_event_handler.sv
// Scoreboard bench for collision_event_handler. The driver pushes the
// hand-computed result of every frame evaluation/restart; the monitor pops
// and compares on the cycle the DUT's registered outputs update.
module tb_collision_event_handler;

    localparam int SW = 5;

    logic          clk;
    logic          resetN;
    logic          startOfFrame;
    logic          collidePlayer;
    logic          collideAlien;
    logic          restart;
    logic          playerHit;
    logic          alienHit;
    logic [2:0]    lives;
    logic [SW-1:0] score;
    logic          invulnerable;
    logic          gameOver;

    typedef struct packed {
        logic          ph;
        logic          ah;
        logic [2:0]    lives;
        logic [SW-1:0] score;
        logic          inv;
        logic          go;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;
    int   frame_no = 0;
    logic eval_seen;

    collision_event_handler #(
        .INIT_LIVES      (3),
        .COOLDOWN_FRAMES (3),
        .ALIEN_POINTS    (10),
        .SCORE_W         (SW)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .collidePlayer (collidePlayer),
        .collideAlien  (collideAlien),
        .restart       (restart),
        .playerHit     (playerHit),
        .alienHit      (alienHit),
        .lives         (lives),
        .score         (score),
        .invulnerable  (invulnerable),
        .gameOver      (gameOver)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Remember which edges should have produced an update.
    always @(posedge clk or negedge resetN) begin
        if (!resetN) eval_seen <= 1'b0;
        else         eval_seen <= startOfFrame | restart;
    end

    // Monitor: compare on evaluation cycles, flag stray pulses elsewhere.
    always @(negedge clk) begin
        exp_t e;
        if (resetN && eval_seen) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL eval_no_expect: DUT updated with no expectation queued (ph=%0b ah=%0b)",
                         playerHit, alienHit);
            end else begin
                e = exp_q.pop_front();
                if (playerHit !== e.ph || alienHit !== e.ah || lives !== e.lives ||
                    score !== e.score || invulnerable !== e.inv || gameOver !== e.go) begin
                    fails++;
                    $display("FAIL eval_frame%0d: got ph=%0b ah=%0b lives=%0d score=%0d inv=%0b go=%0b, expected ph=%0b ah=%0b lives=%0d score=%0d inv=%0b go=%0b",
                             frame_no, playerHit, alienHit, lives, score, invulnerable, gameOver,
                             e.ph, e.ah, e.lives, e.score, e.inv, e.go);
                end else begin
                    passes++;
                end
            end
        end else if (resetN && (playerHit || alienHit)) begin
            checks++;
            fails++;
            $display("FAIL stray_pulse: ph=%0b ah=%0b outside an evaluation cycle, expected 0 0",
                     playerHit, alienHit);
        end
    end

    task automatic drive(input logic sof, input logic cp, input logic ca, input logic rst);
        @(negedge clk);
        startOfFrame  = sof;
        collidePlayer = cp;
        collideAlien  = ca;
        restart       = rst;
    endtask

    // len strobe cycles (first np/na carry collides), then the startOfFrame
    // cycle with optional coincident strobes/restart; expectation is queued
    // for the update that follows.
    task automatic frame(input int len, input int np, input int na,
                         input logic cps, input logic cas, input logic rst,
                         input logic ph, input logic ah, input int lv,
                         input int sc, input logic inv, input logic go);
        exp_t e;
        for (int i = 0; i < len; i++)
            drive(1'b0, i < np, i < na, 1'b0);
        e.ph = ph; e.ah = ah; e.lives = 3'(lv); e.score = SW'(sc); e.inv = inv; e.go = go;
        frame_no++;
        exp_q.push_back(e);
        drive(1'b1, cps, cas, rst);
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (playerHit !== 1'b0 || alienHit !== 1'b0 || lives !== 3'd3 || score !== '0 ||
            invulnerable !== 1'b0 || gameOver !== 1'b0) begin
            fails++;
            $display("FAIL %s: got ph=%0b ah=%0b lives=%0d score=%0d inv=%0b go=%0b, expected 0 0 3 0 0 0",
                     name, playerHit, alienHit, lives, score, invulnerable, gameOver);
        end else begin
            passes++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; collidePlayer = 1'b0;
        collideAlien = 1'b0; restart = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset_state");
        resetN = 1'b1;

        //    len np na cps cas rst | ph ah lv sc inv go
        frame(6, 0, 3, 0, 0, 0,   0, 1, 3, 10, 0, 0);  // one alien event for three strobes
        frame(6, 1, 0, 0, 0, 0,   1, 0, 2, 10, 1, 0);  // player hit -> cooldown
        frame(6, 1, 0, 0, 0, 0,   0, 0, 2, 10, 1, 0);  // cooldown ignores hit
        frame(6, 1, 1, 0, 0, 0,   0, 1, 2, 20, 1, 0);  // aliens still scored in cooldown
        frame(6, 1, 0, 0, 0, 0,   0, 0, 2, 20, 0, 0);  // third cooldown eval -> PLAY
        frame(6, 1, 0, 0, 0, 0,   1, 0, 1, 20, 1, 0);  // hittable again
        frame(6, 0, 0, 0, 0, 0,   0, 0, 1, 20, 1, 0);
        frame(6, 0, 0, 0, 0, 0,   0, 0, 1, 20, 1, 0);
        frame(6, 0, 0, 0, 0, 0,   0, 0, 1, 20, 0, 0);
        frame(6, 0, 0, 1, 0, 0,   0, 0, 1, 20, 0, 0);  // strobe on sof belongs to next frame
        frame(6, 0, 1, 0, 0, 0,   1, 1, 0, 30, 0, 1);  // both events, last life -> game over
        frame(6, 1, 2, 0, 0, 0,   0, 0, 0, 30, 0, 1);  // game over: frozen
        frame(6, 1, 1, 0, 0, 1,   0, 0, 3,  0, 0, 0);  // restart beats evaluation
        frame(6, 0, 1, 0, 0, 0,   0, 1, 3, 10, 0, 0);
        frame(6, 0, 0, 0, 1, 0,   0, 0, 3, 10, 0, 0);  // coincident alien strobe
        frame(0, 0, 0, 0, 0, 0,   0, 1, 3, 20, 0, 0);  // back-to-back sof sees it
        frame(6, 0, 1, 0, 0, 0,   0, 1, 3, 30, 0, 0);
        frame(6, 0, 1, 0, 0, 0,   0, 1, 3, 31, 0, 0);  // saturation
        frame(6, 1, 1, 0, 0, 0,   1, 1, 2, 31, 1, 0);

        // Mid-frame asynchronous reset with strobes pending.
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        #2 resetN = 1'b0;
        #1 check_reset_values("async_reset_midframe");
        @(negedge clk);
        collidePlayer = 1'b0; collideAlien = 1'b0;
        resetN = 1'b1;

        frame(6, 0, 0, 0, 0, 0,   0, 0, 3,  0, 0, 0);  // pre-reset strobes forgotten
        frame(6, 0, 1, 0, 0, 0,   0, 1, 3, 10, 0, 0);

        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL queue_drained: %0d expectations left, expected 0", exp_q.size());
        end else begin
            passes++;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
